axi_wr_arb_2x1: RTL and testbench

Write-path arbiter for a 2-master, 1-slave AXI4 interconnect slice. It owns the complete write transaction (AW, W, B) and generates the `sel`/`enable` pair that drives the `Mux_2x1_en` datapath muxes on the AW and W channels. The grant is locked from address acceptance through the B handshake. It routes VALID/READY between the granted master and the slave, and flags bursts whose WLAST position disagrees with AWLEN.

---
 rtl/axi_ic_pkg.sv | 14 +
 rtl/arb_pick_2.sv | 16 +
 rtl/axi_wr_arb_2x1.sv | 144 ++++++++++++++
 tb/tb_axi_wr_arb_2x1.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect slice: write-path FSM encoding
// and default AWLEN width.
package axi_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    localparam int LEN_W_DEFAULT = 8;

endpackage : axi_ic_pkg

// File: rtl/arb_pick_2.sv
// Two-way request picker: a lone requester always wins; on a tie the winner
// is master 0 (fixed priority) or whichever master was not granted last.
module arb_pick_2 #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o
);

    logic tie_to_m1;

    assign tie_to_m1 = ~FIXED_PRIORITY & ~last_i;
    assign win_o     = req_i[1] & (~req_i[0] | tie_to_m1);

endmodule : arb_pick_2

// File: rtl/axi_wr_arb_2x1.sv
// Write-path arbiter for a 2-master / 1-slave AXI4 slice: locks a grant from
// AW acceptance to the B handshake and drives the AW/W mux sel/enable pair.
//
// state | meaning
// IDLE  | no grant held; arbitrate pending AWVALIDs
// ADDR  | grant held; route AW handshake, capture AWLEN
// DATA  | route W beats, track remaining beats vs WLAST
// RESP  | route B handshake, then release grant
module axi_wr_arb_2x1
    import axi_ic_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int LEN_W          = LEN_W_DEFAULT
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             M0_AWVALID,
    input  logic             M1_AWVALID,
    output logic             M0_AWREADY,
    output logic             M1_AWREADY,
    output logic             S_AWVALID,
    input  logic             S_AWREADY,
    input  logic [LEN_W-1:0] S_AWLEN,
    input  logic             M0_WVALID,
    input  logic             M1_WVALID,
    output logic             M0_WREADY,
    output logic             M1_WREADY,
    output logic             S_WVALID,
    input  logic             S_WREADY,
    input  logic             S_WLAST,
    input  logic             S_BVALID,
    output logic             S_BREADY,
    output logic             M0_BVALID,
    output logic             M1_BVALID,
    input  logic             M0_BREADY,
    input  logic             M1_BREADY,
    output logic             sel,
    output logic             enable,
    output logic             burst_err
);

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    wr_state_e        state_q;
    logic             sel_q;
    logic             enable_q;
    logic             last_q;
    logic             burst_err_q;
    logic [LEN_W-1:0] cnt_q;

    logic win;
    logic in_addr, in_data, in_resp;
    logic g_awvalid, g_wvalid, g_bready;
    logic aw_hs, w_hs, b_hs;

    arb_pick_2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_pick (
        .req_i  ({M1_AWVALID, M0_AWVALID}),
        .last_i (last_q),
        .win_o  (win)
    );

    assign in_addr = (state_q == ST_ADDR);
    assign in_data = (state_q == ST_DATA);
    assign in_resp = (state_q == ST_RESP);

    assign g_awvalid = sel_q ? M1_AWVALID : M0_AWVALID;
    assign g_wvalid  = sel_q ? M1_WVALID  : M0_WVALID;
    assign g_bready  = sel_q ? M1_BREADY  : M0_BREADY;

    // Every routed handshake is qualified by state, so IDLE and reset keep all of them low.
    assign S_AWVALID  = in_addr & g_awvalid;
    assign M0_AWREADY = in_addr & ~sel_q & S_AWREADY;
    assign M1_AWREADY = in_addr &  sel_q & S_AWREADY;

    assign S_WVALID   = in_data & g_wvalid;
    assign M0_WREADY  = in_data & ~sel_q & S_WREADY;
    assign M1_WREADY  = in_data &  sel_q & S_WREADY;

    assign S_BREADY   = in_resp & g_bready;
    assign M0_BVALID  = in_resp & ~sel_q & S_BVALID;
    assign M1_BVALID  = in_resp &  sel_q & S_BVALID;

    assign aw_hs = S_AWVALID & S_AWREADY;
    assign w_hs  = S_WVALID  & S_WREADY;
    assign b_hs  = S_BVALID  & S_BREADY;

    assign sel       = sel_q;
    assign enable    = enable_q;
    assign burst_err = burst_err_q;

    // last_q resets to master 1 so that the first tie goes to master 0.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            last_q      <= 1'b1;
            burst_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (M0_AWVALID || M1_AWVALID) begin
                        sel_q    <= win;
                        enable_q <= 1'b1;
                        state_q  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (aw_hs) begin
                        cnt_q   <= S_AWLEN;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                        if (S_WLAST) begin
                            if (cnt_q != '0) begin
                                burst_err_q <= 1'b1;
                            end
                            state_q <= ST_RESP;
                        end else if (cnt_q == '0) begin
                            burst_err_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (b_hs) begin
                        last_q   <= sel_q;
                        enable_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : axi_wr_arb_2x1

// File: tb/tb_axi_wr_arb_2x1.sv
// Bench for axi_wr_arb_2x1: directed and randomized write transactions checked
// against a transaction-level grant/burst-length model.
module tb_axi_wr_arb_2x1;

    logic       ACLK;
    logic       ARESETN;
    logic       m_awvalid [2];
    logic       m_awready [2];
    logic       m_wvalid  [2];
    logic       m_wready  [2];
    logic       m_bvalid  [2];
    logic       m_bready  [2];
    logic       s_awvalid, s_awready;
    logic [7:0] s_awlen;
    logic       s_wvalid, s_wready, s_wlast;
    logic       s_bvalid, s_bready;
    logic       sel, enable, burst_err;

    logic       fp_rst_n;
    logic       fp_req [2];
    logic       fp_awready0, fp_awready1, fp_s_awvalid;
    logic       fp_wready0, fp_wready1, fp_s_wvalid;
    logic       fp_s_bready, fp_bvalid0, fp_bvalid1;
    logic       fp_sel, fp_enable, fp_burst_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int last_grant;
    bit exp_err;

    axi_wr_arb_2x1 #(.FIXED_PRIORITY(1'b0), .LEN_W(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .M0_AWVALID(m_awvalid[0]), .M1_AWVALID(m_awvalid[1]),
        .M0_AWREADY(m_awready[0]), .M1_AWREADY(m_awready[1]),
        .S_AWVALID(s_awvalid), .S_AWREADY(s_awready), .S_AWLEN(s_awlen),
        .M0_WVALID(m_wvalid[0]), .M1_WVALID(m_wvalid[1]),
        .M0_WREADY(m_wready[0]), .M1_WREADY(m_wready[1]),
        .S_WVALID(s_wvalid), .S_WREADY(s_wready), .S_WLAST(s_wlast),
        .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .M0_BVALID(m_bvalid[0]), .M1_BVALID(m_bvalid[1]),
        .M0_BREADY(m_bready[0]), .M1_BREADY(m_bready[1]),
        .sel(sel), .enable(enable), .burst_err(burst_err)
    );

    // Fixed-priority instance runs on its own: slave and masters always ready.
    axi_wr_arb_2x1 #(.FIXED_PRIORITY(1'b1), .LEN_W(8)) dut_fp (
        .ACLK(ACLK), .ARESETN(fp_rst_n),
        .M0_AWVALID(fp_req[0]), .M1_AWVALID(fp_req[1]),
        .M0_AWREADY(fp_awready0), .M1_AWREADY(fp_awready1),
        .S_AWVALID(fp_s_awvalid), .S_AWREADY(1'b1), .S_AWLEN(8'd0),
        .M0_WVALID(1'b1), .M1_WVALID(1'b1),
        .M0_WREADY(fp_wready0), .M1_WREADY(fp_wready1),
        .S_WVALID(fp_s_wvalid), .S_WREADY(1'b1), .S_WLAST(1'b1),
        .S_BVALID(1'b1), .S_BREADY(fp_s_bready),
        .M0_BVALID(fp_bvalid0), .M1_BVALID(fp_bvalid1),
        .M0_BREADY(1'b1), .M1_BREADY(1'b1),
        .sel(fp_sel), .enable(fp_enable), .burst_err(fp_burst_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Round-robin reference: a lone requester wins, a tie goes to whoever did not go last.
    function automatic int model_pick();
        if (m_awvalid[0] && !m_awvalid[1]) return 0;
        if (m_awvalid[1] && !m_awvalid[0]) return 1;
        return 1 - last_grant;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = 1'b0;
            m_wvalid[i]  = 1'b0;
            m_bready[i]  = 1'b0;
        end
        s_awready = 1'b0;
        s_awlen   = 8'd0;
        s_wready  = 1'b0;
        s_wlast   = 1'b0;
        s_bvalid  = 1'b0;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        clear_inputs();
        step();
        step();
        ARESETN    = 1'b1;
        last_grant = 1;
        exp_err    = 1'b0;
        #1;
    endtask

    // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
    task automatic txn(input int awlen, input int nbeats, input int wmode, input int bdelay,
                       input bit late_req);
        int g, o, k, beats;
        bit hs, ok_stable, ok_iso, ok_resp;
        g = model_pick();
        o = 1 - g;
        ok_stable = 1'b1;
        ok_iso    = 1'b1;
        ok_resp   = 1'b1;
        s_awlen   = 8'(awlen);
        k = 0;
        do begin
            step();
            #1;
            k++;
        end while (!enable && k < 8);
        chk("grant_latency", k, 1);
        chk("grant_sel", sel, g);

        hs = 1'b0;
        for (int i = 0; i < 16 && !hs; i++) begin
            s_awready = (i >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (m_awready[o] !== 1'b0) ok_iso = 1'b0;
            if (m_awready[g] !== s_awready) ok_iso = 1'b0;
            if (sel !== 1'(g) || enable !== 1'b1) ok_stable = 1'b0;
            if (s_awvalid && s_awready) hs = 1'b1;
            step();
        end
        chk("aw_handshake", hs, 1);
        m_awvalid[g] = 1'b0;
        s_awready    = 1'b0;

        m_wvalid[g] = 1'b1;
        beats = 0;
        hs = 1'b0;
        for (int i = 0; i < 64 && !hs; i++) begin
            case (wmode)
                0:       s_wready = 1'b1;
                1:       s_wready = (i % 2 == 1) ? 1'b0 : 1'b1;
                default: s_wready = (i >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            s_wlast = (beats == nbeats - 1);
            if (late_req && i == 1) m_awvalid[o] = 1'b1;
            #1;
            if (sel !== 1'(g) || enable !== 1'b1) ok_stable = 1'b0;
            if (m_wready[o] !== 1'b0 || m_awready[o] !== 1'b0 || m_bvalid[o] !== 1'b0) ok_iso = 1'b0;
            if (s_wvalid && s_wready) begin
                beats++;
                if (s_wlast) hs = 1'b1;
            end
            step();
        end
        m_wvalid[g] = 1'b0;
        s_wready    = 1'b0;
        s_wlast     = 1'b0;
        if (nbeats != awlen + 1) exp_err = 1'b1;
        #1;
        chk("beat_count", beats, nbeats);
        chk("burst_err", burst_err, exp_err);

        s_bvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 16 && !hs; i++) begin
            m_bready[g] = (i >= bdelay);
            #1;
            if (m_bvalid[g] !== 1'b1 || m_bvalid[o] !== 1'b0) ok_resp = 1'b0;
            if (s_bready !== 1'(i >= bdelay)) ok_resp = 1'b0;
            if (sel !== 1'(g) || enable !== 1'b1) ok_stable = 1'b0;
            if (s_bready) hs = 1'b1;
            step();
        end
        chk("b_handshake", hs, 1);
        s_bvalid    = 1'b0;
        m_bready[g] = 1'b0;
        last_grant  = g;
        #1;
        chk("idle_enable", enable, 0);
        chk("idle_awvalid", s_awvalid, 0);
        chk("sel_stable", ok_stable, 1);
        chk("nongrant_quiet", ok_iso, 1);
        chk("resp_routing", ok_resp, 1);
    endtask

    initial begin
        int len, ngr;
        bit prev_en;

        fp_rst_n = 1'b0;
        fp_req[0] = 1'b0;
        fp_req[1] = 1'b0;
        ARESETN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = 1'b1;
            m_wvalid[i]  = 1'b1;
            m_bready[i]  = 1'b1;
        end
        s_awready = 1'b1;
        s_awlen   = 8'd3;
        s_wready  = 1'b1;
        s_wlast   = 1'b1;
        s_bvalid  = 1'b1;
        #22;
        chk("rst_enable", enable, 0);
        chk("rst_sel", sel, 0);
        chk("rst_burst_err", burst_err, 0);
        chk("rst_handshakes",
            {m_awready[0], m_awready[1], s_awvalid, m_wready[0], m_wready[1], s_wvalid,
             s_bready, m_bvalid[0], m_bvalid[1]}, 0);
        do_reset();

        // Single master 1, AWLEN=3, four beats.
        m_awvalid[1] = 1'b1;
        txn(3, 4, 0, 0, 1'b0);

        // Two ties in a row: master 0 first, then master 1.
        m_awvalid[0] = 1'b1;
        m_awvalid[1] = 1'b1;
        txn(0, 1, 0, 0, 1'b0);
        txn(0, 1, 0, 0, 1'b0);

        // Backpressure on W, delayed BREADY, competing master 1 request mid-burst.
        m_awvalid[0] = 1'b1;
        txn(3, 4, 1, 3, 1'b1);
        txn(1, 2, 0, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            if (!m_awvalid[0] && $urandom_range(0, 1) == 1) m_awvalid[0] = 1'b1;
            if (!m_awvalid[1] && $urandom_range(0, 1) == 1) m_awvalid[1] = 1'b1;
            if (!m_awvalid[0] && !m_awvalid[1]) m_awvalid[$urandom_range(0, 1)] = 1'b1;
            len = $urandom_range(0, 7);
            txn(len, len + 1, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Fixed priority: both held requesting, every grant goes to master 0.
        fp_req[0] = 1'b1;
        fp_req[1] = 1'b1;
        fp_rst_n  = 1'b1;
        ngr = 0;
        prev_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            #1;
            if (fp_enable && !prev_en) begin
                ngr++;
                chk("fp_tie_sel", fp_sel, 0);
            end
            prev_en = fp_enable;
        end
        chk("fp_grant_count", ngr, 3);
        fp_rst_n = 1'b0;

        // AWLEN=1 closed by WLAST on the first beat.
        do_reset();
        m_awvalid[0] = 1'b1;
        txn(1, 1, 0, 0, 1'b0);

        // AWLEN=0 with a non-last first beat; WLAST only on beat 2.
        do_reset();
        m_awvalid[1] = 1'b1;
        txn(0, 2, 0, 1, 1'b0);

        // Reset asserted between clock edges while in DATA.
        do_reset();
        m_awvalid[0] = 1'b1;
        step();
        #1;
        chk("mid_enable_pre", enable, 1);
        s_awready = 1'b1;
        s_awlen   = 8'd5;
        step();
        m_awvalid[0] = 1'b0;
        s_awready    = 1'b0;
        m_wvalid[0]  = 1'b1;
        s_wready     = 1'b1;
        #1;
        chk("mid_wvalid_pre", s_wvalid, 1);
        #1;
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_enable", enable, 0);
        chk("mid_rst_wvalid", s_wvalid, 0);
        chk("mid_rst_wready", m_wready[0], 0);
        clear_inputs();
        step();
        ARESETN    = 1'b1;
        last_grant = 1;
        exp_err    = 1'b0;
        step();
        #1;
        chk("post_rst_enable", enable, 0);
        chk("post_rst_burst_err", burst_err, 0);
        m_awvalid[1] = 1'b1;
        txn(2, 3, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_axi_wr_arb_2x1
